// File: rtl/mac_rx_frame_check.sv
// MAC receive frame checker: preamble/SFD strip, CRC-32 and length checks, FCS strip,
// frame-tagged output FIFO with per-frame status and saturating good/bad counters.
module mac_rx_frame_check #(
    parameter bit          CHECK_PREAMBLE = 1'b1,
    parameter bit          STRIP_FCS      = 1'b1,
    parameter int unsigned MIN_LEN        = 64,
    parameter int unsigned MAX_LEN        = 1518,
    parameter int unsigned FIFO_DEPTH     = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             logic_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_err,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [4:0]       m_user,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames
);
    localparam int unsigned H     = STRIP_FCS ? 5 : 1;
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PRE  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] TAIL = 3'd3;
    localparam logic [2:0] DROP = 3'd4;

    typedef struct packed {
        logic [4:0] user;
        logic       last;
        logic [7:0] data;
    } entry_t;

    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        return c;
    endfunction

    logic [2:0]         state_q, state_d;
    logic               armed_q, armed_d;
    logic               collide_q, collide_d;
    logic [31:0]        crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [2:0]         hcnt_q, hcnt_d;
    logic [H-1:0][7:0]  hold_q, hold_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;
    logic               start, done, accum, data_byte, data_wr, tail_wr, inc_good, inc_bad;
    logic [4:0]         status;
    logic               wr_en;
    entry_t             wr_entry;

    entry_t             mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      mem_cnt;
    logic               rd, space, out_load, mem_re, mem_we;

    assign status = {ovf_q, len_q > LEN_W'(MAX_LEN), len_q < LEN_W'(MIN_LEN), err_q, crc_q != RESIDUE};

    // Frame FSM and per-frame accumulators
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q | ~rx_valid;
        collide_d = collide_q;
        crc_d     = crc_q;
        len_d     = len_q;
        hcnt_d    = hcnt_q;
        hold_d    = hold_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        start     = 1'b0;
        done      = 1'b0;
        accum     = 1'b0;
        data_byte = 1'b0;
        data_wr   = 1'b0;
        tail_wr   = 1'b0;
        inc_good  = 1'b0;
        inc_bad   = 1'b0;
        case (state_q)
            IDLE: start = armed_q;
            PRE: begin
                accum = rx_valid;
                if (!rx_valid || (rx_data != 8'h55 && rx_data != 8'hD5)) state_d = DROP;
                else if (rx_data == 8'hD5) state_d = DATA;
            end
            DATA: begin
                if (rx_valid) begin
                    data_byte = 1'b1;
                    accum     = 1'b1;
                end else begin
                    state_d = TAIL;
                end
            end
            TAIL: begin
                if (hcnt_q != 3'(H)) begin
                    inc_bad = 1'b1;
                    done    = 1'b1;
                end else if (space) begin
                    tail_wr  = 1'b1;
                    done     = 1'b1;
                    inc_good = (status == 5'd0);
                    inc_bad  = (status != 5'd0);
                end
                // A frame arriving while the tail waits for space is dropped afterwards
                if (done) begin
                    if (collide_q) begin
                        state_d   = DROP;
                        collide_d = 1'b0;
                    end else begin
                        start = 1'b1;
                    end
                end else if (rx_valid) begin
                    collide_d = 1'b1;
                end
            end
            DROP: begin
                if (!rx_valid) begin
                    inc_bad = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = IDLE;
            crc_d   = '1;
            len_d   = '0;
            hcnt_d  = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            if (rx_valid) begin
                accum = 1'b1;
                if (!CHECK_PREAMBLE) begin
                    state_d   = DATA;
                    data_byte = 1'b1;
                end else begin
                    state_d = (rx_data == 8'h55) ? PRE : DROP;
                end
            end
        end

        // Oldest held byte is pushed to the FIFO once the hold line is full
        if (data_byte) begin
            crc_d = crc_upd(crc_d, rx_data);
            if (len_d != LEN_W'(MAX_LEN + 1)) len_d = len_d + LEN_W'(1);
            hold_d[0] = rx_data;
            for (int unsigned i = 1; i < H; i++) hold_d[i] = hold_q[i-1];
            if (hcnt_d == 3'(H)) begin
                if (!ovf_d) begin
                    if (space) data_wr = 1'b1;
                    else       ovf_d   = 1'b1;
                end
            end else begin
                hcnt_d = hcnt_d + 3'd1;
            end
        end
        err_d = err_d | (accum & rx_err);

        wr_en         = data_wr | tail_wr;
        wr_entry.user = tail_wr ? status : 5'd0;
        wr_entry.last = tail_wr;
        wr_entry.data = hold_q[H-1];
    end

    always_ff @(posedge clk or posedge logic_rst) begin
        if (logic_rst) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            collide_q   <= 1'b0;
            crc_q       <= '1;
            len_q       <= '0;
            hcnt_q      <= '0;
            hold_q      <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            good_frames <= '0;
            bad_frames  <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            collide_q <= collide_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            hcnt_q    <= hcnt_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            if (inc_good && good_frames != '1) good_frames <= good_frames + CNT_W'(1);
            if (inc_bad && bad_frames != '1)   bad_frames  <= bad_frames + CNT_W'(1);
        end
    end

    // FWFT FIFO: memory plus the output register; total occupancy limited to FIFO_DEPTH
    assign rd       = m_valid & m_ready;
    assign space    = ((mem_cnt + CW'(m_valid)) != CW'(FIFO_DEPTH)) | rd;
    assign out_load = ~m_valid | rd;
    assign mem_re   = out_load & (mem_cnt != '0);
    assign mem_we   = wr_en & ~(out_load & (mem_cnt == '0));

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge logic_rst) begin
        if (logic_rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_user  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (out_load) begin
                if (mem_re) begin
                    {m_user, m_last, m_data} <= mem[rd_ptr];
                    m_valid <= 1'b1;
                    rd_ptr  <= rd_ptr + AW'(1);
                end else if (wr_en) begin
                    {m_user, m_last, m_data} <= wr_entry;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end
            if (mem_we) wr_ptr <= wr_ptr + AW'(1);
            if (mem_we && !mem_re)      mem_cnt <= mem_cnt + CW'(1);
            else if (mem_re && !mem_we) mem_cnt <= mem_cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_mac_rx_frame_check.sv
// Scoreboard bench for mac_rx_frame_check: three configurations, expected beats queued at
// stimulus time and popped by an independent output monitor.
module tb_mac_rx_frame_check;
    logic       clk = 1'b0;
    logic       logic_rst;
    logic [7:0] rx_data [3];
    logic       rx_valid [3];
    logic       rx_err [3];
    logic       m_ready [3];
    logic [7:0] m_data [3];
    logic       m_valid [3];
    logic       m_last [3];
    logic [4:0] m_user [3];
    logic [15:0] good [3];
    logic [15:0] bad [3];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       last;
        logic [4:0] user;
    } exp_t;
    exp_t exp_q [$];
    logic [7:0] fr [$];
    logic [7:0] all_q [$];
    logic [7:0] pl [$];

    always #5 clk = ~clk;

    // inst 0: MIN_LEN=4; inst 1: defaults; inst 2: no preamble, FCS forwarded
    mac_rx_frame_check #(.MIN_LEN(4)) u_a (
        .clk(clk), .logic_rst(logic_rst), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .rx_err(rx_err[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .m_last(m_last[0]), .m_user(m_user[0]), .good_frames(good[0]), .bad_frames(bad[0]));
    mac_rx_frame_check u_b (
        .clk(clk), .logic_rst(logic_rst), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .rx_err(rx_err[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .m_last(m_last[1]), .m_user(m_user[1]), .good_frames(good[1]), .bad_frames(bad[1]));
    mac_rx_frame_check #(.CHECK_PREAMBLE(1'b0), .STRIP_FCS(1'b0)) u_c (
        .clk(clk), .logic_rst(logic_rst), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
        .rx_err(rx_err[2]), .m_data(m_data[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
        .m_last(m_last[2]), .m_user(m_user[2]), .good_frames(good[2]), .bad_frames(bad[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int inst, input logic [7:0] d, input logic last, input logic [4:0] user);
        exp_t e;
        e.inst = inst; e.d = d; e.last = last; e.user = user;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int inst, input logic v, input logic [7:0] d, input logic e);
        rx_valid[inst] = v;
        rx_data[inst]  = d;
        rx_err[inst]   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_fcs();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (fr[i]) begin
            c = c ^ {24'h0, fr[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
    endtask

    task automatic send_frame(input int inst, input bit pre, input int err_at);
        if (pre) begin
            repeat (7) drive(inst, 1'b1, 8'h55, 1'b0);
            drive(inst, 1'b1, 8'hD5, 1'b0);
        end
        foreach (fr[i]) drive(inst, 1'b1, fr[i], (i == err_at));
        drive(inst, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout: %0d beats still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        idle(3);
    endtask

    task automatic load_123456789(input logic [7:0] last_fcs);
        fr.delete();
        for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
        fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(last_fcs);
    endtask

    // Output monitor: every accepted beat must match the head of the scoreboard
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (m_valid[g] && m_ready[g]) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat inst=%0d data=%02h last=%0b user=%05b, required no output",
                             g, m_data[g], m_last[g], m_user[g]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.inst != g || m_data[g] !== e.d || m_last[g] !== e.last ||
                        (e.last && m_user[g] !== e.user)) begin
                        errors++;
                        $display("FAIL beat inst=%0d: got data=%02h last=%0b user=%05b, required inst=%0d data=%02h last=%0b user=%05b",
                                 g, m_data[g], m_last[g], m_user[g], e.inst, e.d, e.last, e.user);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic_rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            rx_data[g] = 8'h00; rx_valid[g] = 1'b0; rx_err[g] = 1'b0; m_ready[g] = 1'b1;
        end
        idle(3);
        logic_rst = 1'b0;
        idle(3);

        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset_m_valid_%0d", g), 32'(m_valid[g]), 32'd0);
            check($sformatf("reset_good_%0d", g), 32'(good[g]), 32'd0);
            check($sformatf("reset_bad_%0d", g), 32'(bad[g]), 32'd0);
        end

        // Good "123456789" frame, MIN_LEN=4
        load_123456789(8'hCB);
        for (int i = 0; i < 9; i++) push_exp(0, 8'h31 + 8'(i), (i == 8), 5'b00000);
        send_frame(0, 1'b1, -1);
        wait_drain("good_frame");
        check("good_frame_good", 32'(good[0]), 32'd1);
        check("good_frame_bad", 32'(bad[0]), 32'd0);

        // Corrupted FCS with MIN_LEN=64: crc_err and runt
        load_123456789(8'hCA);
        for (int i = 0; i < 9; i++) push_exp(1, 8'h31 + 8'(i), (i == 8), 5'b00101);
        send_frame(1, 1'b1, -1);
        wait_drain("bad_crc");
        check("bad_crc_bad", 32'(bad[1]), 32'd1);
        check("bad_crc_good", 32'(good[1]), 32'd0);

        // Bad preamble is dropped entirely
        drive(1, 1'b1, 8'h55, 1'b0);
        drive(1, 1'b1, 8'h55, 1'b0);
        drive(1, 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 20; i++) drive(1, 1'b1, 8'(i + 16), 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        idle(5);
        check("bad_pre_m_valid", 32'(m_valid[1]), 32'd0);
        check("bad_pre_bad", 32'(bad[1]), 32'd2);
        check("bad_pre_good", 32'(good[1]), 32'd0);

        // No preamble, FCS forwarded: 64-byte frame, then the same with an rx_err pulse
        fr.delete();
        for (int i = 0; i < 60; i++) fr.push_back(8'(i * 7 + 3));
        add_fcs();
        for (int i = 0; i < 64; i++) push_exp(2, fr[i], (i == 63), 5'b00000);
        send_frame(2, 1'b0, -1);
        wait_drain("fcs_fwd");
        check("fcs_fwd_good", 32'(good[2]), 32'd1);
        for (int i = 0; i < 64; i++) push_exp(2, fr[i], (i == 63), 5'b00010);
        send_frame(2, 1'b0, 20);
        wait_drain("phy_err");
        check("phy_err_bad", 32'(bad[2]), 32'd1);
        check("phy_err_good", 32'(good[2]), 32'd1);

        // Backpressure: 100-byte frame into a 64-entry FIFO
        m_ready[0] = 1'b0;
        fr.delete();
        for (int i = 0; i < 96; i++) fr.push_back(8'(i + 100));
        add_fcs();
        for (int i = 0; i < 64; i++) push_exp(0, fr[i], 1'b0, 5'b00000);
        push_exp(0, fr[95], 1'b1, 5'b10000);
        send_frame(0, 1'b1, -1);
        idle(20);
        check("bp_m_valid_held", 32'(m_valid[0]), 32'd1);
        check("bp_head_data", 32'(m_data[0]), 32'(fr[0]));
        check("bp_bad_before_tail", 32'(bad[0]), 32'd0);
        m_ready[0] = 1'b1;
        wait_drain("backpressure");
        check("bp_bad_after", 32'(bad[0]), 32'd1);
        check("bp_good_after", 32'(good[0]), 32'd1);

        // Reset at byte 30 of a 72-byte run; the rest of the run must be ignored
        m_ready[0] = 1'b0;
        fr.delete();
        for (int i = 0; i < 60; i++) fr.push_back(8'(i ^ 8'h5A));
        add_fcs();
        all_q.delete();
        repeat (7) all_q.push_back(8'h55);
        all_q.push_back(8'hD5);
        foreach (fr[i]) all_q.push_back(fr[i]);
        foreach (all_q[i]) begin
            if (i == 30) logic_rst = 1'b1;
            if (i == 33) logic_rst = 1'b0;
            drive(0, 1'b1, all_q[i], 1'b0);
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        idle(5);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_mid_m_valid_%0d", g), 32'(m_valid[g]), 32'd0);
            check($sformatf("rst_mid_good_%0d", g), 32'(good[g]), 32'd0);
            check($sformatf("rst_mid_bad_%0d", g), 32'(bad[g]), 32'd0);
        end
        m_ready[0] = 1'b1;
        load_123456789(8'hCB);
        for (int i = 0; i < 9; i++) push_exp(0, 8'h31 + 8'(i), (i == 8), 5'b00000);
        send_frame(0, 1'b1, -1);
        wait_drain("after_reset");
        check("after_reset_good", 32'(good[0]), 32'd1);
        check("after_reset_bad", 32'(bad[0]), 32'd0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
